// File: rtl/core_ctrl_if.sv
// Data-memory handshake between the control sequencer and the memory port.
interface core_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/core_ctrl.sv
// Multi-cycle control sequencer for the RV32 datapath: FETCH/EXEC/MEM/HALT,
// with a retired-instruction counter and a data-memory watchdog.
module core_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    core_ctrl_if.master      mem,
    output logic             pc_en,
    output logic             PCSrc,
    output logic             ResultSrc,
    output logic [2:0]       ALUControl,
    output logic             ALUSrc,
    output logic [2:0]       ImmSrc,
    output logic             RegWrite,
    output logic             Branch,
    output logic             RegSrc,
    output logic             halted,
    output logic             err_timeout,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [7:0] TmoLast = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

    state_e           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic             err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0] instret_q;
    logic             retire;
    logic             mem_req_c;
    logic             mem_we_c;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [2:0] alu_fn;
    logic       alu_fn_ok;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7_5     = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    // ALU function from funct3; funct7[5] selects sub only for R-type add.
    always_comb begin
        alu_fn    = 3'b000;
        alu_fn_ok = 1'b1;
        case (funct3)
            3'b000:  alu_fn = (opcode == OpR && funct7_5) ? 3'b001 : 3'b000;
            3'b111:  alu_fn = 3'b010;
            3'b110:  alu_fn = 3'b011;
            3'b010:  alu_fn = 3'b101;
            default: alu_fn_ok = 1'b0;
        endcase
    end

    // Next-state and control outputs; every strobe defaults low.
    always_comb begin
        state_d       = state_q;
        is_store_d    = is_store_q;
        tmo_cnt_d     = tmo_cnt_q;
        err_timeout_d = err_timeout_q;
        retire        = 1'b0;
        pc_en         = 1'b0;
        PCSrc         = 1'b0;
        ResultSrc     = 1'b0;
        ALUControl    = 3'b000;
        ALUSrc        = 1'b0;
        ImmSrc        = 3'b000;
        RegWrite      = 1'b0;
        Branch        = 1'b0;
        mem_req_c     = 1'b0;
        mem_we_c      = 1'b0;
        halted        = 1'b0;
        unique case (state_q)
            StFetch: state_d = StExec;
            StExec: begin
                case (opcode)
                    OpR, OpI: begin
                        if (alu_fn_ok) begin
                            ALUSrc     = (opcode == OpI);
                            ALUControl = alu_fn;
                            RegWrite   = 1'b1;
                            pc_en      = 1'b1;
                            retire     = 1'b1;
                            state_d    = StFetch;
                        end else begin
                            state_d = StHalt;
                        end
                    end
                    OpLoad, OpStore: begin
                        ALUSrc     = 1'b1;
                        ImmSrc     = (opcode == OpStore) ? 3'b001 : 3'b000;
                        is_store_d = (opcode == OpStore);
                        tmo_cnt_d  = 8'd0;
                        state_d    = StMem;
                    end
                    OpBranch: begin
                        if (funct3 == 3'b000 || funct3 == 3'b001) begin
                            ALUControl = 3'b001;
                            ImmSrc     = 3'b010;
                            Branch     = 1'b1;
                            // bne (funct3[0]=1) takes the branch when not zero
                            PCSrc      = alu_zero ^ funct3[0];
                            pc_en      = 1'b1;
                            retire     = 1'b1;
                            state_d    = StFetch;
                        end else begin
                            state_d = StHalt;
                        end
                    end
                    default: state_d = StHalt;
                endcase
            end
            StMem: begin
                ALUSrc    = 1'b1;
                ImmSrc    = is_store_q ? 3'b001 : 3'b000;
                mem_req_c = 1'b1;
                mem_we_c  = is_store_q;
                // A ready arriving on the last watchdog cycle still completes.
                if (mem.mem_ready) begin
                    RegWrite  = ~is_store_q;
                    ResultSrc = ~is_store_q;
                    pc_en     = 1'b1;
                    retire    = 1'b1;
                    state_d   = StFetch;
                end else if (tmo_cnt_q == TmoLast) begin
                    err_timeout_d = 1'b1;
                    state_d       = StHalt;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            StHalt: halted = 1'b1;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StFetch;
            is_store_q    <= 1'b0;
            tmo_cnt_q     <= 8'd0;
            err_timeout_q <= 1'b0;
            instret_q     <= '0;
        end else begin
            state_q       <= state_d;
            is_store_q    <= is_store_d;
            tmo_cnt_q     <= tmo_cnt_d;
            err_timeout_q <= err_timeout_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign mem.mem_req = mem_req_c;
    assign mem.mem_we  = mem_we_c;
    assign RegSrc      = 1'b0;
    assign err_timeout = err_timeout_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl with a short watchdog and a 4-bit instret.
module tb_core_ctrl;

    localparam logic [31:0] ADD  = 32'h003100B3;
    localparam logic [31:0] ORI  = 32'h00516093;
    localparam logic [31:0] SUB  = 32'h403100B3;
    localparam logic [31:0] SLTI = 32'h00512093;
    localparam logic [31:0] LW   = 32'h00802283;
    localparam logic [31:0] SW   = 32'h00502423;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] BNE  = 32'h00209463;
    localparam logic [31:0] BLT  = 32'h0020C463;
    localparam logic [31:0] ILL  = 32'h0000007F;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        alu_zero;
    logic        pc_en;
    logic        PCSrc;
    logic        ResultSrc;
    logic [2:0]  ALUControl;
    logic        ALUSrc;
    logic [2:0]  ImmSrc;
    logic        RegWrite;
    logic        Branch;
    logic        RegSrc;
    logic        halted;
    logic        err_timeout;
    logic [3:0]  instret;

    int checks = 0;
    int errors = 0;

    core_ctrl_if mem_bus ();

    core_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .alu_zero    (alu_zero),
        .mem         (mem_bus),
        .pc_en       (pc_en),
        .PCSrc       (PCSrc),
        .ResultSrc   (ResultSrc),
        .ALUControl  (ALUControl),
        .ALUSrc      (ALUSrc),
        .ImmSrc      (ImmSrc),
        .RegWrite    (RegWrite),
        .Branch      (Branch),
        .RegSrc      (RegSrc),
        .halted      (halted),
        .err_timeout (err_timeout),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, drive inputs, let outputs settle.
    task automatic step(input logic [31:0] i, input logic r, input logic z);
        @(negedge clk);
        instr             = i;
        mem_bus.mem_ready = r;
        alu_zero          = z;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset             = 1'b0;
        instr             = 32'h0;
        alu_zero          = 1'b0;
        mem_bus.mem_ready = 1'b0;
        step(32'h0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_regsrc", 32'(RegSrc), 32'd0);
        reset = 1'b1;
        instr = ADD;

        // add: EXEC on the first cycle after release
        step(ADD, 1'b0, 1'b0);
        chk("add_regwrite", 32'(RegWrite), 32'd1);
        chk("add_pc_en", 32'(pc_en), 32'd1);
        chk("add_aluctl", 32'(ALUControl), 32'd0);
        chk("add_alusrc", 32'(ALUSrc), 32'd0);
        chk("add_instret_pre", 32'(instret), 32'd0);
        step(ORI, 1'b0, 1'b0);
        chk("fetch_instret", 32'(instret), 32'd1);
        chk("fetch_pc_en", 32'(pc_en), 32'd0);
        chk("fetch_regwrite", 32'(RegWrite), 32'd0);
        step(ORI, 1'b0, 1'b0);
        chk("ori_aluctl", 32'(ALUControl), 32'd3);
        chk("ori_alusrc", 32'(ALUSrc), 32'd1);
        chk("ori_regwrite", 32'(RegWrite), 32'd1);
        step(SUB, 1'b0, 1'b0);
        step(SUB, 1'b0, 1'b0);
        chk("sub_aluctl", 32'(ALUControl), 32'd1);
        chk("sub_alusrc", 32'(ALUSrc), 32'd0);
        step(SLTI, 1'b0, 1'b0);
        step(SLTI, 1'b0, 1'b0);
        chk("slti_aluctl", 32'(ALUControl), 32'd5);

        // lw with three wait cycles
        step(LW, 1'b0, 1'b0);
        chk("lw_pre_instret", 32'(instret), 32'd4);
        step(LW, 1'b0, 1'b0);
        chk("lw_exec_mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("lw_exec_pc_en", 32'(pc_en), 32'd0);
        chk("lw_exec_immsrc", 32'(ImmSrc), 32'd0);
        chk("lw_exec_alusrc", 32'(ALUSrc), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(LW, 1'b0, 1'b0);
            chk("lw_wait_mem_req", 32'(mem_bus.mem_req), 32'd1);
            chk("lw_wait_pc_en", 32'(pc_en), 32'd0);
            chk("lw_wait_regwrite", 32'(RegWrite), 32'd0);
        end
        step(LW, 1'b1, 1'b0);
        chk("lw_done_mem_req", 32'(mem_bus.mem_req), 32'd1);
        chk("lw_done_mem_we", 32'(mem_bus.mem_we), 32'd0);
        chk("lw_done_regwrite", 32'(RegWrite), 32'd1);
        chk("lw_done_resultsrc", 32'(ResultSrc), 32'd1);
        chk("lw_done_pc_en", 32'(pc_en), 32'd1);
        step(SW, 1'b0, 1'b0);
        chk("lw_after_mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("lw_after_instret", 32'(instret), 32'd5);

        // sw completing in its first MEM cycle
        step(SW, 1'b0, 1'b0);
        chk("sw_exec_immsrc", 32'(ImmSrc), 32'd1);
        step(SW, 1'b1, 1'b0);
        chk("sw_mem_req", 32'(mem_bus.mem_req), 32'd1);
        chk("sw_mem_we", 32'(mem_bus.mem_we), 32'd1);
        chk("sw_regwrite", 32'(RegWrite), 32'd0);
        chk("sw_pc_en", 32'(pc_en), 32'd1);

        // branches
        step(BEQ, 1'b0, 1'b1);
        chk("sw_after_instret", 32'(instret), 32'd6);
        step(BEQ, 1'b0, 1'b1);
        chk("beq_z1_pcsrc", 32'(PCSrc), 32'd1);
        chk("beq_z1_branch", 32'(Branch), 32'd1);
        chk("beq_z1_immsrc", 32'(ImmSrc), 32'd2);
        chk("beq_z1_aluctl", 32'(ALUControl), 32'd1);
        chk("beq_z1_pc_en", 32'(pc_en), 32'd1);
        chk("beq_z1_regwrite", 32'(RegWrite), 32'd0);
        step(BEQ, 1'b0, 1'b0);
        step(BEQ, 1'b0, 1'b0);
        chk("beq_z0_pcsrc", 32'(PCSrc), 32'd0);
        chk("beq_z0_branch", 32'(Branch), 32'd1);
        step(BNE, 1'b0, 1'b1);
        step(BNE, 1'b0, 1'b1);
        chk("bne_z1_pcsrc", 32'(PCSrc), 32'd0);
        step(BNE, 1'b0, 1'b0);
        step(BNE, 1'b0, 1'b0);
        chk("bne_z0_pcsrc", 32'(PCSrc), 32'd1);
        step(ADD, 1'b0, 1'b0);
        chk("br_after_instret", 32'(instret), 32'd10);
        chk("fetch_branch", 32'(Branch), 32'd0);

        // instret wrap at 4 bits
        step(ADD, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(ADD, 1'b0, 1'b0);
            step(ADD, 1'b0, 1'b0);
        end
        step(ADD, 1'b0, 1'b0);
        chk("instret_15", 32'(instret), 32'd15);
        step(ADD, 1'b0, 1'b0);
        step(LW, 1'b0, 1'b0);
        chk("instret_wrap", 32'(instret), 32'd0);

        // watchdog trip after four MEM cycles
        step(LW, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(LW, 1'b0, 1'b0);
            chk("tmo_wait_mem_req", 32'(mem_bus.mem_req), 32'd1);
            chk("tmo_wait_regwrite", 32'(RegWrite), 32'd0);
            chk("tmo_wait_halted", 32'(halted), 32'd0);
        end
        step(LW, 1'b0, 1'b0);
        chk("tmo_halted", 32'(halted), 32'd1);
        chk("tmo_err", 32'(err_timeout), 32'd1);
        chk("tmo_mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("tmo_regwrite", 32'(RegWrite), 32'd0);
        chk("tmo_instret", 32'(instret), 32'd0);
        step(LW, 1'b1, 1'b0);
        chk("tmo_sticky_err", 32'(err_timeout), 32'd1);
        chk("tmo_sticky_pc_en", 32'(pc_en), 32'd0);
        reset = 1'b0;
        step(ILL, 1'b0, 1'b0);
        chk("tmo_rst_halted", 32'(halted), 32'd0);
        chk("tmo_rst_err", 32'(err_timeout), 32'd0);
        reset = 1'b1;

        // illegal opcode
        step(ILL, 1'b0, 1'b0);
        chk("ill_exec_pc_en", 32'(pc_en), 32'd0);
        chk("ill_exec_regwrite", 32'(RegWrite), 32'd0);
        chk("ill_exec_halted", 32'(halted), 32'd0);
        for (int k = 0; k < 20; k++) begin
            step(ILL, 1'b0, 1'b0);
            chk("ill_halted", 32'(halted), 32'd1);
            chk("ill_pc_en", 32'(pc_en), 32'd0);
        end
        chk("ill_no_err", 32'(err_timeout), 32'd0);
        reset = 1'b0;
        step(BLT, 1'b0, 1'b0);
        chk("ill_rst_halted", 32'(halted), 32'd0);
        reset = 1'b1;

        // unsupported branch funct3
        step(BLT, 1'b0, 1'b0);
        chk("blt_pc_en", 32'(pc_en), 32'd0);
        step(BLT, 1'b0, 1'b0);
        chk("blt_halted", 32'(halted), 32'd1);
        reset = 1'b0;
        step(LW, 1'b0, 1'b0);
        reset = 1'b1;

        // ready on the last watchdog cycle wins
        step(LW, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(LW, 1'b0, 1'b0);
        end
        step(LW, 1'b1, 1'b0);
        chk("late_pc_en", 32'(pc_en), 32'd1);
        chk("late_regwrite", 32'(RegWrite), 32'd1);
        chk("late_halted", 32'(halted), 32'd0);
        step(LW, 1'b0, 1'b0);
        chk("late_instret", 32'(instret), 32'd1);
        chk("late_halted_after", 32'(halted), 32'd0);
        chk("late_err", 32'(err_timeout), 32'd0);

        // reset during a MEM wait
        step(LW, 1'b0, 1'b0);
        step(LW, 1'b0, 1'b0);
        chk("mrst_mem_req_pre", 32'(mem_bus.mem_req), 32'd1);
        reset = 1'b0;
        step(LW, 1'b0, 1'b0);
        chk("mrst_mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("mrst_instret", 32'(instret), 32'd0);
        chk("mrst_halted", 32'(halted), 32'd0);
        reset = 1'b1;
        step(LW, 1'b0, 1'b0);
        chk("mrst_exec_alusrc", 32'(ALUSrc), 32'd1);
        chk("mrst_exec_mem_req", 32'(mem_bus.mem_req), 32'd0);
        step(LW, 1'b0, 1'b0);
        chk("mrst_mem_again", 32'(mem_bus.mem_req), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
